lidar_frame_proc: RTL and testbench
===================================

Name: lidar_frame_proc

Overview:
Upstream neighbour of the UART transmit stage. Consumes the LiDAR byte stream from the UART receiver, finds the 0x55 0xAA header and parses a fixed-length distance frame. It computes the max-distance angle, the min-distance angle and an obstacle alert, then loads the 48-bit result into the transmitter and starts transmission over the flashin/flashout handshake.

Parameters:
NUM_SAMPLES, 8, distance samples per frame; sample i is at angle i*ANGLE_STEP.
ANGLE_STEP, 45, angle increment per sample, in degrees.
OBS_THRESH, 300, obstacle threshold in mm (16-bit).
TX_TIMEOUT, 255, maximum cycles in SEND before flashout is forced low.

Ports:
clock  input  1  system clock; all logic on its rising edge.
reset  input  1  synchronous, active-low reset.
rx_byte  input  8  byte from the UART receiver.
rx_valid  input  1  one-cycle strobe; rx_byte is valid this cycle.
tx_busy  input  1  busy flag from the transmit stage.
lidar_header  output  16  constant 16'h55AA.
data  output  48  {max_angle[15:0], min_angle[15:0], obs_alert[15:0]}.
flashin  output  1  load strobe to the transmitter.
flashout  output  1  transmit enable to the transmitter.
frame_err  output  1  one-cycle pulse on checksum mismatch.
tx_timeout  output  1  one-cycle pulse when SEND times out.
busy  output  1  high in LOAD, GAP and SEND.

Behaviour:
- Reset when reset==0 at a rising clock edge. Reset values: state=HDR1, data=0, flashin=0, flashout=0, frame_err=0, tx_timeout=0, busy=0. All accumulators are cleared.
- lidar_header is driven as 16'h55AA at all times, including during reset.
- Frame format: 0x55, 0xAA, then NUM_SAMPLES 16-bit distances sent MSB first, then 1 checksum byte. The checksum is the XOR of all 2*NUM_SAMPLES payload bytes; header bytes are excluded.
- States advance only on rx_valid, except LOAD, GAP and SEND.
- HDR1: on byte 0x55 go to HDR2; any other byte stays in HDR1.
- HDR2: on 0xAA go to MSB and clear the sample index, checksum and trackers. On 0x55 stay in HDR2. Any other byte returns to HDR1.
- MSB: latch the high byte and go to LSB.
- LSB: form the distance and update the trackers (rules below).
  - If the index is NUM_SAMPLES-1, go to CSUM.
  - Otherwise increment the index and go to MSB.
- Tracker rules:
  - Distance 0 is invalid and ignored.
  - max updates only on strictly greater; min updates only on strictly less. Ties therefore keep the lowest index.
  - Angle value = index*ANGLE_STEP, 16-bit, zero-extended.
- CSUM, byte matches the running XOR: the next cycle updates data and enters LOAD.
  - With no valid sample: max_angle=min_angle=16'hFFFF and obs_alert=0.
  - Otherwise obs_alert=16'h0001 if min distance < OBS_THRESH, else 16'h0000.
- CSUM, byte mismatches: frame_err pulses for 1 cycle, go to HDR1, data is unchanged.
- LOAD: flashin=1 for exactly 2 cycles, then GAP.
- GAP: flashin=0 and flashout=0 for 1 cycle, then SEND.
- SEND: flashout=1.
  - Track whether tx_busy has been seen high.
  - Once tx_busy has been high and is then observed low, drop flashout and go to HDR1.
  - If the cycle counter reaches TX_TIMEOUT first: pulse tx_timeout, drop flashout, go to HDR1.
- data is stable from entry to LOAD until the next valid frame. It never changes during LOAD, GAP or SEND.
- rx_valid bytes arriving during LOAD, GAP or SEND are dropped. Parsing restarts in HDR1.
- A header inside the payload is not resynchronised; a corrupted frame is caught by the checksum.
- Reset mid-frame or mid-SEND: the next cycle shows all outputs at reset values and flashout low.

Test Plan:
- Good frame: distances [500,1200,800,250,900,1200,0,700] with correct XOR -> data=48'h002D_0087_0001. flashin high for 2 cycles, 1 gap cycle, then flashout high.
- Handshake: tx_busy rises 3 cycles into SEND and falls 64 cycles later -> flashout drops the cycle after tx_busy is seen low; busy returns to 0.
- Bad checksum (valid frame, checksum ^ 8'h01) -> frame_err pulses 1 cycle; data keeps its previous value; flashin never asserts.
- All zeros (distances all 0) -> data=48'hFFFF_FFFF_0000. All 1000 -> data=48'h0000_0000_0000.
- Header resync: bytes 0x55,0x55,0xAA then a good frame -> parsed correctly. Bytes 0x55,0x12,0xAA -> stays in HDR1.
- Timeout and reset: tx_busy tied 0 -> tx_timeout pulses after 255 SEND cycles and flashout drops. Reset=0 mid-payload -> outputs at reset values next cycle; the following good frame parses normally.

Source files
------------

// File: rtl/lidar_frame_proc.sv
// LiDAR frame parser: locks onto the 0x55 0xAA header, parses NUM_SAMPLES
// 16-bit distances plus an XOR checksum, and hands the 48-bit max/min-angle
// and obstacle result to the UART transmitter over the flashin/flashout handshake.
module lidar_frame_proc #(
  parameter int unsigned NUM_SAMPLES = 8,
  parameter int unsigned ANGLE_STEP  = 45,
  parameter int unsigned OBS_THRESH  = 300,
  parameter int unsigned TX_TIMEOUT  = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  rx_byte,
  input  logic        rx_valid,
  input  logic        tx_busy,
  output logic [15:0] lidar_header,
  output logic [47:0] data,
  output logic        flashin,
  output logic        flashout,
  output logic        frame_err,
  output logic        tx_timeout,
  output logic        busy
);

  localparam int unsigned IDX_W = (NUM_SAMPLES > 1) ? $clog2(NUM_SAMPLES) : 1;
  localparam int unsigned CNT_W = $clog2(TX_TIMEOUT + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SAMPLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TX_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] LOAD_LAST = CNT_W'(1);
  localparam logic [15:0] THRESH = 16'(OBS_THRESH);

  typedef enum logic [2:0] {
    S_HDR1, S_HDR2, S_MSB, S_LSB, S_CSUM, S_LOAD, S_GAP, S_SEND
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic             w_frame_err;
  logic             w_tx_timeout;

  logic [IDX_W-1:0] r_idx;
  logic [7:0]       r_msb;
  logic [7:0]       r_csum;
  logic             r_any;
  logic [15:0]      r_max_d;
  logic [15:0]      r_min_d;
  logic [IDX_W-1:0] r_max_idx;
  logic [IDX_W-1:0] r_min_idx;
  logic [CNT_W-1:0] r_cnt;
  logic             r_seen;
  logic [47:0]      r_data;
  logic             r_flashin;
  logic             r_flashout;
  logic             r_frame_err;
  logic             r_tx_timeout;
  logic             r_busy;

  logic [15:0]      w_dist;
  logic             w_upd_max;
  logic             w_upd_min;
  logic [15:0]      w_max_angle;
  logic [15:0]      w_min_angle;
  logic [15:0]      w_alert;

  assign lidar_header = 16'h55AA;
  assign data         = r_data;
  assign flashin      = r_flashin;
  assign flashout     = r_flashout;
  assign frame_err    = r_frame_err;
  assign tx_timeout   = r_tx_timeout;
  assign busy         = r_busy;

  // Distance being completed this cycle and whether it moves a tracker (0 is invalid)
  assign w_dist    = {r_msb, rx_byte};
  assign w_upd_max = (w_dist != 16'd0) && (!r_any || (w_dist > r_max_d));
  assign w_upd_min = (w_dist != 16'd0) && (!r_any || (w_dist < r_min_d));

  // Result fields; a frame with no valid sample reports 0xFFFF angles and no alert
  assign w_max_angle = r_any ? 16'(32'(r_max_idx) * ANGLE_STEP) : 16'hFFFF;
  assign w_min_angle = r_any ? 16'(32'(r_min_idx) * ANGLE_STEP) : 16'hFFFF;
  assign w_alert     = (r_any && (r_min_d < THRESH)) ? 16'h0001 : 16'h0000;

  // State register
  always_ff @(posedge clock) begin
    if (!reset) r_state <= S_HDR1;
    else        r_state <= w_next;
  end

  // Next-state logic and single-cycle event strobes
  always_comb begin
    w_next       = r_state;
    w_frame_err  = 1'b0;
    w_tx_timeout = 1'b0;
    case (r_state)
      S_HDR1: if (rx_valid && (rx_byte == 8'h55)) w_next = S_HDR2;
      S_HDR2: begin
        if (rx_valid) begin
          if (rx_byte == 8'hAA)      w_next = S_MSB;
          else if (rx_byte != 8'h55) w_next = S_HDR1;
        end
      end
      S_MSB:  if (rx_valid) w_next = S_LSB;
      S_LSB:  if (rx_valid) w_next = (r_idx == LAST_IDX) ? S_CSUM : S_MSB;
      S_CSUM: begin
        if (rx_valid) begin
          if (rx_byte == r_csum) begin
            w_next = S_LOAD;
          end else begin
            w_next      = S_HDR1;
            w_frame_err = 1'b1;
          end
        end
      end
      S_LOAD: if (r_cnt == LOAD_LAST) w_next = S_GAP;
      S_GAP:  w_next = S_SEND;
      S_SEND: begin
        if (r_seen && !tx_busy) begin
          w_next = S_HDR1;
        end else if (r_cnt == TMO_LAST) begin
          w_next       = S_HDR1;
          w_tx_timeout = 1'b1;
        end
      end
      default: w_next = S_HDR1;
    endcase
  end

  // Payload accumulators, result register and registered handshake outputs
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_idx        <= '0;
      r_msb        <= '0;
      r_csum       <= '0;
      r_any        <= 1'b0;
      r_max_d      <= '0;
      r_min_d      <= '0;
      r_max_idx    <= '0;
      r_min_idx    <= '0;
      r_cnt        <= '0;
      r_seen       <= 1'b0;
      r_data       <= '0;
      r_flashin    <= 1'b0;
      r_flashout   <= 1'b0;
      r_frame_err  <= 1'b0;
      r_tx_timeout <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      // Per-state cycle counter, restarted on every state change
      r_cnt <= (w_next != r_state) ? '0 : r_cnt + CNT_W'(1);

      if (r_state != S_SEND) r_seen <= 1'b0;
      else if (tx_busy)      r_seen <= 1'b1;

      case (r_state)
        S_HDR2: begin
          if (rx_valid && (rx_byte == 8'hAA)) begin
            r_idx     <= '0;
            r_csum    <= '0;
            r_any     <= 1'b0;
            r_max_d   <= '0;
            r_min_d   <= '0;
            r_max_idx <= '0;
            r_min_idx <= '0;
          end
        end
        S_MSB: begin
          if (rx_valid) begin
            r_msb  <= rx_byte;
            r_csum <= r_csum ^ rx_byte;
          end
        end
        S_LSB: begin
          if (rx_valid) begin
            r_csum <= r_csum ^ rx_byte;
            if (w_upd_max) begin
              r_max_d   <= w_dist;
              r_max_idx <= r_idx;
            end
            if (w_upd_min) begin
              r_min_d   <= w_dist;
              r_min_idx <= r_idx;
            end
            if (w_dist != 16'd0) r_any <= 1'b1;
            if (r_idx != LAST_IDX) r_idx <= r_idx + IDX_W'(1);
          end
        end
        S_CSUM: begin
          if (rx_valid && (rx_byte == r_csum)) r_data <= {w_max_angle, w_min_angle, w_alert};
        end
        default: ;
      endcase

      r_flashin    <= (w_next == S_LOAD);
      r_flashout   <= (w_next == S_SEND);
      r_busy       <= (w_next == S_LOAD) || (w_next == S_GAP) || (w_next == S_SEND);
      r_frame_err  <= w_frame_err;
      r_tx_timeout <= w_tx_timeout;
    end
  end

endmodule

// File: tb/tb_lidar_frame_proc.sv
// Scoreboard bench for lidar_frame_proc: directed frames push expected events,
// a negedge monitor pops and compares them when the DUT signals a result.
module tb_lidar_frame_proc;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  rx_byte = 8'h00;
  logic        rx_valid = 1'b0;
  logic        tx_busy = 1'b0;
  logic [15:0] lidar_header;
  logic [47:0] data;
  logic        flashin;
  logic        flashout;
  logic        frame_err;
  logic        tx_timeout;
  logic        busy;

  lidar_frame_proc dut (
    .clock        (clock),
    .reset        (reset),
    .rx_byte      (rx_byte),
    .rx_valid     (rx_valid),
    .tx_busy      (tx_busy),
    .lidar_header (lidar_header),
    .data         (data),
    .flashin      (flashin),
    .flashout     (flashout),
    .frame_err    (frame_err),
    .tx_timeout   (tx_timeout),
    .busy         (busy)
  );

  always #5 clock = ~clock;

  typedef enum int {EV_FRAME = 0, EV_ERR = 1, EV_TMO = 2} ev_kind_t;
  typedef struct {
    ev_kind_t    kind;
    logic [47:0] data;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  logic [15:0] dv[8];

  always @(posedge clock) cyc++;

  task automatic check(string name, logic [63:0] act, logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic expect_ev(ev_kind_t k, logic [47:0] d);
    exp_t e;
    e.kind = k;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic pop_compare(ev_kind_t k);
    exp_t e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_errors++;
      $display("FAIL unexpected_event: got kind %0d data %h, expected no event", k, data);
    end else begin
      e = exp_q.pop_front();
      if ((e.kind != k) || (data !== e.data)) begin
        n_errors++;
        $display("FAIL event: got kind %0d data %h, expected kind %0d data %h",
                 k, data, e.kind, e.data);
      end
    end
  endtask

  // Monitor: result events and LOAD/GAP/SEND sequencing
  logic prev_fi = 1'b0;
  logic prev_fo = 1'b0;
  int   fi_rise = 0;
  int   fi_len  = 0;
  always @(negedge clock) begin
    if (reset === 1'b1) begin
      if (flashin && !prev_fi) begin
        fi_rise = cyc;
        fi_len  = 0;
        pop_compare(EV_FRAME);
      end
      if (flashin) fi_len++;
      if (!flashin && prev_fi) check("flashin_len", 64'(fi_len), 64'd2);
      if (flashout && !prev_fo) check("load_to_flashout", 64'(cyc - fi_rise), 64'd3);
      if (frame_err) pop_compare(EV_ERR);
      if (tx_timeout) pop_compare(EV_TMO);
    end
    prev_fi = flashin;
    prev_fo = flashout;
  end

  task automatic send_byte(logic [7:0] b);
    @(negedge clock);
    rx_byte  = b;
    rx_valid = 1'b1;
  endtask

  task automatic idle(int n);
    repeat (n) begin
      @(negedge clock);
      rx_valid = 1'b0;
    end
  endtask

  task automatic send_payload(logic [7:0] cx);
    logic [7:0] cs;
    cs = 8'h00;
    for (int i = 0; i < 8; i++) begin
      send_byte(dv[i][15:8]);
      send_byte(dv[i][7:0]);
      cs = cs ^ dv[i][15:8] ^ dv[i][7:0];
    end
    send_byte(cs ^ cx);
    idle(1);
  endtask

  task automatic send_frame(logic [7:0] cx);
    send_byte(8'h55);
    send_byte(8'hAA);
    send_payload(cx);
  endtask

  task automatic wait_flashout(logic lvl, int bound, output int n);
    n = 0;
    while ((flashout !== lvl) && (n < bound)) begin
      @(negedge clock);
      n++;
    end
    if (flashout !== lvl) begin
      n_checks++;
      n_errors++;
      $display("FAIL wait_flashout: flashout is %b, expected %b within %0d cycles", flashout, lvl, bound);
    end
  endtask

  task automatic handshake();
    int n;
    wait_flashout(1'b1, 20, n);
    repeat (3) @(negedge clock);
    tx_busy = 1'b1;
    repeat (64) @(negedge clock);
    check("flashout_while_busy", 64'(flashout), 64'd1);
    tx_busy = 1'b0;
    @(negedge clock);
    check("flashout_after_busy", 64'(flashout), 64'd0);
    check("busy_after_send", 64'(busy), 64'd0);
  endtask

  task automatic check_reset_vals(string tag);
    check({tag, "_data"}, 64'(data), 64'd0);
    check({tag, "_flashin"}, 64'(flashin), 64'd0);
    check({tag, "_flashout"}, 64'(flashout), 64'd0);
    check({tag, "_frame_err"}, 64'(frame_err), 64'd0);
    check({tag, "_tx_timeout"}, 64'(tx_timeout), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_header"}, 64'(lidar_header), 64'h55AA);
  endtask

  initial begin
    int n;

    // Power-on reset
    reset = 1'b0;
    idle(3);
    check_reset_vals("por");
    reset = 1'b1;
    idle(2);

    // Good frame with full tx_busy handshake
    dv = '{16'd500, 16'd1200, 16'd800, 16'd250, 16'd900, 16'd1200, 16'd0, 16'd700};
    expect_ev(EV_FRAME, 48'h002D_0087_0001);
    send_frame(8'h00);
    handshake();

    // Corrupted checksum: error pulse, data held, no load
    expect_ev(EV_ERR, 48'h002D_0087_0001);
    send_frame(8'h01);
    idle(10);
    check("bad_csum_busy", 64'(busy), 64'd0);
    check("bad_csum_data", 64'(data), 64'h002D_0087_0001);

    // All distances invalid
    dv = '{16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
    expect_ev(EV_FRAME, 48'hFFFF_FFFF_0000);
    send_frame(8'h00);
    handshake();

    // All equal distances above threshold: ties keep index 0
    dv = '{16'd1000, 16'd1000, 16'd1000, 16'd1000, 16'd1000, 16'd1000, 16'd1000, 16'd1000};
    expect_ev(EV_FRAME, 48'h0000_0000_0000);
    send_frame(8'h00);
    handshake();

    // Repeated 0x55 before 0xAA still synchronises
    send_byte(8'h55);
    dv = '{16'd100, 16'd0, 16'd0, 16'd2000, 16'd50, 16'd3000, 16'd3000, 16'd400};
    expect_ev(EV_FRAME, 48'h00E1_00B4_0001);
    send_frame(8'h00);
    handshake();

    // Broken header 0x55 0x12 0xAA: following payload must be ignored
    send_byte(8'h55);
    send_byte(8'h12);
    send_byte(8'hAA);
    dv = '{16'd1000, 16'd1000, 16'd1000, 16'd1000, 16'd1000, 16'd1000, 16'd1000, 16'd1000};
    send_payload(8'h00);
    idle(10);
    check("bad_hdr_busy", 64'(busy), 64'd0);
    check("bad_hdr_data", 64'(data), 64'h00E1_00B4_0001);

    // Threshold boundary and SEND timeout with tx_busy held low
    dv = '{16'd299, 16'd300, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
    expect_ev(EV_FRAME, 48'h002D_0000_0001);
    expect_ev(EV_TMO, 48'h002D_0000_0001);
    send_frame(8'h00);
    wait_flashout(1'b1, 20, n);
    wait_flashout(1'b0, 400, n);
    check("send_len_timeout", 64'(n), 64'd255);
    check("timeout_busy", 64'(busy), 64'd0);

    // Reset in the middle of a payload, then a normal frame
    send_byte(8'h55);
    send_byte(8'hAA);
    send_byte(8'h03);
    send_byte(8'hE8);
    send_byte(8'h00);
    @(negedge clock);
    rx_valid = 1'b0;
    reset    = 1'b0;
    @(negedge clock);
    check_reset_vals("mid_frame");
    reset = 1'b1;
    idle(2);
    dv = '{16'd500, 16'd1200, 16'd800, 16'd250, 16'd900, 16'd1200, 16'd0, 16'd700};
    expect_ev(EV_FRAME, 48'h002D_0087_0001);
    send_frame(8'h00);
    handshake();

    // Reset during SEND
    expect_ev(EV_FRAME, 48'h002D_0087_0001);
    send_frame(8'h00);
    wait_flashout(1'b1, 20, n);
    idle(5);
    reset = 1'b0;
    @(negedge clock);
    check_reset_vals("mid_send");
    reset = 1'b1;
    idle(3);

    check("events_outstanding", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global time bound so the bench always terminates
  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete, expected finish before time limit");
    $fatal(1, "timeout");
  end

endmodule
